// File: rtl/dma_periph_pkg.sv
// rtl/dma_periph_pkg.sv - shared types and sizing helper for the DMA I/O peripheral
package dma_periph_pkg;

    typedef enum int unsigned {
        IDLE_IDX    = 0,
        REQ_IDX     = 1,
        ACK_IDX     = 2,
        STROBE_IDX  = 3,
        RECOVER_IDX = 4
    } periph_state_idx_e;

    typedef enum logic [4:0] {
        S_IDLE    = 5'b00001,
        S_REQ     = 5'b00010,
        S_ACK     = 5'b00100,
        S_STROBE  = 5'b01000,
        S_RECOVER = 5'b10000
    } periph_state_e;

    typedef enum logic {
        DIR_SOURCE = 1'b0,
        DIR_SINK   = 1'b1
    } dir_e;

    // One extra pointer bit distinguishes full from empty.
    function automatic int level_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/dma_periph_fifo.sv
// rtl/dma_periph_fifo.sv - synchronous FIFO with full/empty/level for the DMA I/O peripheral
module dma_periph_fifo
    import dma_periph_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8,
    localparam int LW        = level_width(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] head,
    output logic                  full,
    output logic                  empty,
    output logic [LW-1:0]         level
);

    localparam int AW = LW - 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [LW-1:0]         wptr;
    logic [LW-1:0]         rptr;
    logic                  do_push;
    logic                  do_pop;

    assign level   = wptr - rptr;
    assign full    = (level == LW'(DEPTH));
    assign empty   = (wptr == rptr);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem[rptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + LW'(1);
            if (do_pop)  rptr <= rptr + LW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/dma_io_peripheral.sv
// rtl/dma_io_peripheral.sv - DREQ/DACK peripheral endpoint; DMA_PERIPH_DEMAND_EN selects demand mode
module dma_io_peripheral
    import dma_periph_pkg::*;
#(
    parameter int DATA_WIDTH    = 8,
    parameter int DEPTH         = 8,
    parameter int REQ_THRESHOLD = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  dir,
    output logic                  dreq,
    input  logic                  dack,
    input  logic                  ior_n,
    input  logic                  iow_n,
    input  logic                  eop_n,
    input  logic [DATA_WIDTH-1:0] db_in,
    output logic [DATA_WIDTH-1:0] db_out,
    output logic                  db_oe,
    input  logic [DATA_WIDTH-1:0] loc_wdata,
    input  logic                  loc_wvalid,
    output logic                  loc_wready,
    output logic [DATA_WIDTH-1:0] loc_rdata,
    output logic                  loc_rvalid,
    input  logic                  loc_rready,
    output logic                  tc,
    input  logic                  tc_clr
);

    localparam int LW = level_width(DEPTH);
    localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
    localparam logic [LW-1:0] THR_L   = LW'(REQ_THRESHOLD);

    periph_state_e         state, state_next;
    dir_e                  dir_q;
    logic                  eop_pend;
    logic                  tc_set;
    logic                  dreq_d;
    logic                  strobe_low;
    logic                  eop;
    logic                  bus_push, bus_pop, drive;
    logic [DATA_WIDTH-1:0] head;
    logic                  full, empty;
    logic [LW-1:0]         level;
`ifdef DMA_PERIPH_DEMAND_EN
    logic                  more_ok;
`endif

    function automatic logic ready_for(input dir_e d, input logic [LW-1:0] lvl);
        if (d == DIR_SOURCE) return lvl >= THR_L;
        return (DEPTH_L - lvl) >= THR_L;
    endfunction

    // Only the strobe matching the latched direction is ever looked at.
    assign strobe_low = (dir_q == DIR_SOURCE) ? ~ior_n : ~iow_n;
    assign eop        = ~eop_n & dack;
`ifdef DMA_PERIPH_DEMAND_EN
    assign more_ok    = (dir_q == DIR_SOURCE) ? (level >= LW'(2)) : (level < DEPTH_L);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            dir_q    <= DIR_SOURCE;
            dreq     <= 1'b0;
            eop_pend <= 1'b0;
            tc       <= 1'b0;
        end else begin
            state    <= state_next;
            if (state == S_IDLE) dir_q <= dir_e'(dir);
            dreq     <= dreq_d;
            eop_pend <= (state == S_STROBE) && (state_next == S_STROBE) && (eop_pend || eop);
            if (tc_set)      tc <= 1'b1;
            else if (tc_clr) tc <= 1'b0;
        end
    end

    always_comb begin
        state_next = state;
        tc_set     = 1'b0;
        case (state)
            S_IDLE:    if (ready_for(dir_e'(dir), level)) state_next = S_REQ;
            S_REQ: begin
                if (!ready_for(dir_q, level)) state_next = S_IDLE;
                else if (dack)                state_next = S_ACK;
            end
            S_ACK: begin
                if (!dack)           state_next = S_IDLE;
                else if (strobe_low) state_next = S_STROBE;
            end
            S_STROBE: begin
                // An EOP seen mid-strobe is held until the strobe releases.
                if (!strobe_low) begin
                    if (eop || eop_pend) begin
                        state_next = S_IDLE;
                        tc_set     = 1'b1;
                    end
`ifdef DMA_PERIPH_DEMAND_EN
                    else if (dack && more_ok) state_next = S_ACK;
`endif
                    else state_next = S_RECOVER;
                end
            end
            S_RECOVER: state_next = S_IDLE;
            default:   state_next = S_IDLE;
        endcase
        if (eop && state != S_STROBE) begin
            state_next = S_IDLE;
            tc_set     = 1'b1;
        end
    end

    always_comb begin
        bus_push = (state == S_ACK) && (state_next == S_STROBE) && (dir_q == DIR_SINK);
        bus_pop  = (state == S_STROBE) && !strobe_low && (dir_q == DIR_SOURCE);
        drive    = (state[ACK_IDX] || state[STROBE_IDX]) && (dir_q == DIR_SOURCE);
        db_out   = drive ? head : '0;
        db_oe    = drive & dack & ~ior_n;
        dreq_d   = (state[REQ_IDX] || state[ACK_IDX] || state[STROBE_IDX]) &&
                   (state_next[REQ_IDX] || state_next[ACK_IDX] || state_next[STROBE_IDX]);
    end

    assign loc_wready = ~full;
    assign loc_rvalid = ~empty;
    assign loc_rdata  = head;

    // Bus side owns the FIFO port when both sides touch the same end.
    dma_periph_fifo #(
        .DATA_WIDTH(DATA_WIDTH),
        .DEPTH     (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (bus_push | loc_wvalid),
        .push_data(bus_push ? db_in : loc_wdata),
        .pop      (bus_pop | loc_rready),
        .head     (head),
        .full     (full),
        .empty    (empty),
        .level    (level)
    );

endmodule

// File: tb/tb_dma_io_peripheral.sv
// tb/tb_dma_io_peripheral.sv - self-checking bench for dma_io_peripheral
module tb_dma_io_peripheral;

    logic       clk = 1'b0;
    logic       reset, dir, dreq, dack, ior_n, iow_n, eop_n, db_oe;
    logic [7:0] db_in, db_out, loc_wdata, loc_rdata;
    logic       loc_wvalid, loc_wready, loc_rvalid, loc_rready, tc, tc_clr;

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [7:0] sb[$];
    int         mlevel = 0;

    typedef struct {
        logic       dir;
        logic [7:0] data;
        logic [7:0] exp;
    } vec_t;
    vec_t vecs[6];

    always #5 clk = ~clk;

    dma_io_peripheral dut (
        .clk(clk), .reset(reset), .dir(dir), .dreq(dreq), .dack(dack),
        .ior_n(ior_n), .iow_n(iow_n), .eop_n(eop_n), .db_in(db_in),
        .db_out(db_out), .db_oe(db_oe), .loc_wdata(loc_wdata),
        .loc_wvalid(loc_wvalid), .loc_wready(loc_wready), .loc_rdata(loc_rdata),
        .loc_rvalid(loc_rvalid), .loc_rready(loc_rready), .tc(tc), .tc_clr(tc_clr)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        sb.delete();
        mlevel = 0;
    endtask

    task automatic local_push(input logic [7:0] d);
        loc_wdata  = d;
        loc_wvalid = 1'b1;
        tick();
        loc_wvalid = 1'b0;
        if (mlevel < 8) begin
            sb.push_back(d);
            mlevel++;
        end
    endtask

    task automatic local_pop_check(input string name);
        check({name, " valid"}, loc_rvalid, 1);
        if (sb.size() > 0) begin
            check({name, " data"}, loc_rdata, sb[0]);
            void'(sb.pop_front());
            mlevel--;
        end
        loc_rready = 1'b1;
        tick();
        loc_rready = 1'b0;
    endtask

    task automatic wait_dreq(input string name, output int n);
        n = 0;
        while (!dreq && n < 10) begin
            tick();
            n++;
        end
        check({name, " dreq"}, dreq, 1);
    endtask

    task automatic bus_read(input string name, input logic [7:0] exp);
        dack = 1'b1;
        tick();
        ior_n = 1'b0;
        #1;
        check({name, " oe"}, db_oe, 1);
        check({name, " db_out"}, db_out, exp);
        tick();
        check({name, " db_out held"}, db_out, exp);
        ior_n = 1'b1;
        tick();
        void'(sb.pop_front());
        mlevel--;
        check({name, " recover dreq"}, dreq, 0);
        dack = 1'b0;
        tick();
    endtask

    task automatic bus_write(input string name, input logic [7:0] d, input int lows);
        dack = 1'b1;
        tick();
        db_in = d;
        iow_n = 1'b0;
        #1;
        check({name, " no oe"}, db_oe, 0);
        repeat (lows) tick();
        iow_n = 1'b1;
        tick();
        dack = 1'b0;
        tick();
        sb.push_back(d);
        mlevel++;
    endtask

    task automatic read_pulse(input string name);
        ior_n = 1'b0;
        tick();
        check({name, " oe"}, db_oe, 1);
        if (sb.size() > 0) check({name, " db_out"}, db_out, sb[0]);
        tick();
        ior_n = 1'b1;
        tick();
        void'(sb.pop_front());
        mlevel--;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int  n;
        logic dropped;

        vecs[0] = '{1'b0, 8'hA5, 8'hA5};
        vecs[1] = '{1'b0, 8'h5A, 8'h5A};
        vecs[2] = '{1'b0, 8'hFF, 8'hFF};
        vecs[3] = '{1'b1, 8'h3C, 8'h3C};
        vecs[4] = '{1'b1, 8'h00, 8'h00};
        vecs[5] = '{1'b1, 8'hC3, 8'hC3};

        reset = 1'b1; dir = 1'b0; dack = 1'b0; ior_n = 1'b1; iow_n = 1'b1;
        eop_n = 1'b1; db_in = '0; loc_wdata = '0; loc_wvalid = 1'b0;
        loc_rready = 1'b0; tc_clr = 1'b0;
        tick();
        tick();
        check("rst dreq", dreq, 0);
        check("rst db_oe", db_oe, 0);
        check("rst db_out", db_out, 0);
        check("rst tc", tc, 0);
        check("rst rvalid", loc_rvalid, 0);
        check("rst wready", loc_wready, 1);
        reset = 1'b0;

        // Reset in the middle of a bus read, FIFO holding data
        local_push(8'hA1);
        local_push(8'hA2);
        local_push(8'hA3);
        wait_dreq("pre-reset", n);
        dack = 1'b1;
        tick();
        ior_n = 1'b0;
        #1;
        check("pre-reset oe", db_oe, 1);
        reset = 1'b1;
        tick();
        check("mid-reset oe", db_oe, 0);
        tick();
        reset = 1'b0;
        check("post-reset dreq", dreq, 0);
        check("post-reset oe", db_oe, 0);
        check("post-reset tc", tc, 0);
        check("post-reset rvalid", loc_rvalid, 0);
        ior_n = 1'b1;
        dack = 1'b0;
        sb.delete();
        mlevel = 0;
        tick();

        // Table of single transfers: sources first, then sinks
        for (int i = 0; i < 6; i++) begin
            dir = vecs[i].dir;
            if (!vecs[i].dir) begin
                local_push(vecs[i].data);
                wait_dreq($sformatf("src%0d", i), n);
                check($sformatf("src%0d latency<=2", i), (n <= 2), 1);
                bus_read($sformatf("src%0d", i), vecs[i].exp);
                check($sformatf("src%0d empty", i), loc_rvalid, 0);
            end else begin
                wait_dreq($sformatf("snk%0d", i), n);
                bus_write($sformatf("snk%0d", i), vecs[i].data, 2);
                check($sformatf("snk%0d loc_rdata", i), loc_rdata, vecs[i].exp);
                local_pop_check($sformatf("snk%0d pop", i));
                check($sformatf("snk%0d single push", i), loc_rvalid, 0);
            end
        end

        // Sink at level 7: bus push and local pop together, then overfill
        do_reset();
        for (int k = 0; k < 7; k++) local_push(8'h10 + 8'(k));
        wait_dreq("lvl7", n);
        dack = 1'b1;
        tick();
        db_in = 8'h77;
        iow_n = 1'b0;
        loc_rready = 1'b1;
        check("simul pop data", loc_rdata, sb[0]);
        tick();
        loc_rready = 1'b0;
        void'(sb.pop_front());
        sb.push_back(8'h77);
        iow_n = 1'b1;
        tick();
        dack = 1'b0;
        tick();
        check("lvl7 not full", loc_wready, 1);
        local_push(8'h88);
        check("full wready", loc_wready, 0);
        local_push(8'h99);
        tick();
        tick();
        check("full dreq gated", dreq, 0);
        for (int k = 0; k < 8; k++) local_pop_check($sformatf("drain%0d", k));
        check("drain empty", loc_rvalid, 0);

        // Terminal count during a source transfer
        dir = 1'b0;
        do_reset();
        local_push(8'h11);
        local_push(8'h22);
        wait_dreq("tc", n);
        dack = 1'b1;
        tick();
        ior_n = 1'b0;
        tick();
        eop_n = 1'b0;
        tick();
        check("tc before complete", tc, 0);
        check("tc db_out held", db_out, 8'h11);
        ior_n = 1'b1;
        eop_n = 1'b1;
        tick();
        void'(sb.pop_front());
        mlevel--;
        check("tc set", tc, 1);
        check("tc dreq", dreq, 0);
        check("tc one pop", loc_rdata, 8'h22);
        dack = 1'b0;
        tc_clr = 1'b1;
        tick();
        tc_clr = 1'b0;
        check("tc clr", tc, 0);
        eop_n = 1'b0;
        tick();
        eop_n = 1'b1;
        check("eop no dack", tc, 0);

        // Four back-to-back reads with DACK held
        local_push(8'h33);
        local_push(8'h44);
        local_push(8'h55);
        dack = 1'b1;
        dropped = 1'b0;
        for (int k = 0; k < 4; k++) begin
            wait_dreq($sformatf("b2b%0d", k), n);
            read_pulse($sformatf("b2b%0d", k));
            if (k < 3 && !dreq) dropped = 1'b1;
        end
        check("b2b final dreq", dreq, 0);
        check("b2b drained", loc_rvalid, 0);
`ifdef DMA_PERIPH_DEMAND_EN
        check("b2b dreq held", dropped, 0);
`else
        check("b2b dreq dropped", dropped, 1);
`endif
        dack = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
